// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// requester port indices and default geometry.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 255;

    // Wide enough for the largest legal TIMEOUT (65535).
    localparam int CNT_W = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side command/response bus. The arbiter is the master; the memory
// (or the bench standing in for it) is the slave.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic            m_req;
    logic [AW-1:0]   m_addr;
    logic            m_we;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_ready;
    logic            m_rvalid;
    logic [DW-1:0]   m_rdata;

    modport master (
        output m_req, m_addr, m_we, m_wdata, m_wstrb,
        input  m_ready, m_rvalid, m_rdata
    );

    modport slave (
        input  m_req, m_addr, m_we, m_wdata, m_wstrb,
        output m_ready, m_rvalid, m_rdata
    );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins outright;
// on a tie the port that did not win last time goes first.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       win_o
);

    // Select the winning port index from the request pattern.
    always_comb begin
        valid_o = 1'b0;
        win_o   = PORT_FETCH;
        case (req_i)
            2'b01: begin
                valid_o = 1'b1;
                win_o   = PORT_FETCH;
            end
            2'b10: begin
                valid_o = 1'b1;
                win_o   = PORT_LSU;
            end
            2'b11: begin
                valid_o = 1'b1;
                win_o   = ~last_i;
            end
            default: begin
                valid_o = 1'b0;
                win_o   = PORT_FETCH;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (port 0) and load/store
// (port 1). One outstanding transaction; a watchdog turns a stalled
// transaction into an error response so the requester never hangs.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_i,
    input  logic                req1_i,
    input  logic [AW-1:0]       addr0_i,
    input  logic [AW-1:0]       addr1_i,
    input  logic                we0_i,
    input  logic                we1_i,
    input  logic [DW-1:0]       wdata0_i,
    input  logic [DW-1:0]       wdata1_i,
    input  logic [DW/8-1:0]     wstrb0_i,
    input  logic [DW/8-1:0]     wstrb1_i,
    output logic                gnt0_o,
    output logic                gnt1_o,
    output logic                rsp_valid0_o,
    output logic                rsp_valid1_o,
    output logic                rsp_err_o,
    output logic [DW-1:0]       rsp_rdata_o,
    mem_port_arbiter_if.master  m_bus
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            last_gnt_q, last_gnt_d;
    logic            m_req_q, m_req_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic            m_we_q, m_we_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;
    logic [DW/8-1:0] m_wstrb_q, m_wstrb_d;
    logic            gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic            rsp_valid0_q, rsp_valid0_d, rsp_valid1_q, rsp_valid1_d;
    logic            rsp_err_q, rsp_err_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic            pick_valid_s, pick_win_s;
    logic            fin_s;

    rr_pick2 u_pick (
        .req_i   ({req1_i, req0_i}),
        .last_i  (last_gnt_q),
        .valid_o (pick_valid_s),
        .win_o   (pick_win_s)
    );

    // State, command and response registers; last_gnt resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            last_gnt_q   <= PORT_LSU;
            m_req_q      <= 1'b0;
            m_addr_q     <= {AW{1'b0}};
            m_we_q       <= 1'b0;
            m_wdata_q    <= {DW{1'b0}};
            m_wstrb_q    <= {(DW/8){1'b0}};
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= {DW{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_gnt_q   <= last_gnt_d;
            m_req_q      <= m_req_d;
            m_addr_q     <= m_addr_d;
            m_we_q       <= m_we_d;
            m_wdata_q    <= m_wdata_d;
            m_wstrb_q    <= m_wstrb_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            rsp_valid0_q <= rsp_valid0_d;
            rsp_valid1_q <= rsp_valid1_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    // Next-state logic: grant in IDLE, complete or time out in ISSUE/WAIT.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_gnt_d   = last_gnt_q;
        m_req_d      = m_req_q;
        m_addr_d     = m_addr_q;
        m_we_d       = m_we_q;
        m_wdata_d    = m_wdata_q;
        m_wstrb_d    = m_wstrb_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = {DW{1'b0}};
        fin_s        = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    if (pick_win_s == PORT_LSU) begin
                        m_addr_d  = addr1_i;
                        m_we_d    = we1_i;
                        m_wdata_d = wdata1_i;
                        m_wstrb_d = wstrb1_i;
                        gnt1_d    = 1'b1;
                    end else begin
                        m_addr_d  = addr0_i;
                        m_we_d    = we0_i;
                        m_wdata_d = wdata0_i;
                        m_wstrb_d = wstrb0_i;
                        gnt0_d    = 1'b1;
                    end
                    last_gnt_d = pick_win_s;
                    m_req_d    = 1'b1;
                    cnt_d      = {CNT_W{1'b0}};
                    state_d    = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // A completion beats a timeout landing in the same cycle.
                if (m_bus.m_ready && (m_we_q || m_bus.m_rvalid)) begin
                    fin_s = 1'b1;
                    if (m_we_q) begin
                        rsp_rdata_d = {DW{1'b0}};
                    end else begin
                        rsp_rdata_d = m_bus.m_rdata;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    fin_s     = 1'b1;
                    rsp_err_d = 1'b1;
                end else if (m_bus.m_ready) begin
                    m_req_d = 1'b0;
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            WAIT: begin
                if (m_bus.m_rvalid) begin
                    fin_s       = 1'b1;
                    rsp_rdata_d = m_bus.m_rdata;
                end else if (cnt_q == TMO_LAST) begin
                    fin_s     = 1'b1;
                    rsp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
        // The granted port is remembered in last_gnt, so it routes the response.
        if (fin_s) begin
            m_req_d      = 1'b0;
            state_d      = IDLE;
            rsp_valid0_d = (last_gnt_q == PORT_FETCH);
            rsp_valid1_d = (last_gnt_q == PORT_LSU);
        end else begin
            rsp_valid0_d = 1'b0;
            rsp_valid1_d = 1'b0;
        end
    end

    assign gnt0_o         = gnt0_q;
    assign gnt1_o         = gnt1_q;
    assign rsp_valid0_o   = rsp_valid0_q;
    assign rsp_valid1_o   = rsp_valid1_q;
    assign rsp_err_o      = rsp_err_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign m_bus.m_req    = m_req_q;
    assign m_bus.m_addr   = m_addr_q;
    assign m_bus.m_we     = m_we_q;
    assign m_bus.m_wdata  = m_wdata_q;
    assign m_bus.m_wstrb  = m_wstrb_q;

endmodule
